uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
`timescale 1ns / 1ps
// Command decoder sitting between the UART RX byte stream, the register file, the ALU and the
// TX FIFO. Parses AA/BB/CC/DD frames and returns read/ALU results as TX bytes.
module uart_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY
);

  localparam logic [DATA_WIDTH-1:0] OpWrite  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OpRead   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OpAluOp  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OpAluNop = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StAluA,
    StAluB, StAluFun, StAluWait, StTxRd, StTxLo, StTxHi
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0]   rd_byte_q, rd_byte_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    rd_byte_d = rd_byte_q;
    alu_res_d = alu_res_q;
    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OpWrite:  state_d = StWrAddr;
            OpRead:   state_d = StRdAddr;
            OpAluOp:  state_d = StAluA;
            OpAluNop: state_d = StAluFun;
            default:  state_d = StIdle;
          endcase
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = StWrData;
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        if (RdData_Valid) begin
          rd_byte_d = RdData;
          state_d   = StTxRd;
        end
      end
      // ALU operands live at fixed register addresses 0 and 1.
      StAluA: begin
        if (RX_D_VLD) begin
          address_d = '0;
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StAluB;
        end
      end
      StAluB: begin
        if (RX_D_VLD) begin
          address_d = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StAluFun;
        end
      end
      StAluFun: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          state_d   = StAluWait;
        end
      end
      StAluWait: begin
        if (OUT_VALID) begin
          alu_res_d = ALU_OUT;
          state_d   = StTxLo;
        end
      end
      StTxRd: begin
        if (!FIFO_FULL) begin
          tx_data_d = rd_byte_q;
          tx_vld_d  = 1'b1;
          state_d   = StIdle;
        end
      end
      StTxLo: begin
        if (!FIFO_FULL) begin
          tx_data_d = alu_res_q[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = StTxHi;
        end
      end
      StTxHi: begin
        if (!FIFO_FULL) begin
          tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_d  = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      address_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      rd_byte_q <= '0;
      alu_res_q <= '0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      rd_byte_q <= rd_byte_d;
      alu_res_q <= alu_res_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CLK_EN    = (state_q == StAluFun) || (state_q == StAluWait);
  assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns / 1ps
// Bench for uart_cmd_ctrl: directed command table, hand-timed latency/reset sequences and
// random command frames scored against a frame-level model of expected bus events.
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = 8'h00;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, BUSY;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;

  uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RdData(RdData),
    .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // One command frame: bytes (byte 0 in the LSBs), response to give, expected bus events.
  typedef struct {
    int          nb;
    logic [39:0] bytes;
    int          rk;    // 0 none, 1 RdData, 2 ALU_OUT
    logic [15:0] resp;
    int          full;  // cycles FIFO_FULL is held after the response
    int          n_wr;
    logic [11:0] wr0, wr1;
    int          n_rd;
    logic [3:0]  rd_addr;
    int          n_alu;
    logic [3:0]  fun;
    int          n_tx;
    logic [7:0]  tx0, tx1;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [11:0] wr_seen[$];
  logic [3:0]  rd_seen[$];
  logic [3:0]  alu_seen[$];
  logic [7:0]  tx_seen[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (WrEn) wr_seen.push_back({Address, WrData});
      if (RdEn) rd_seen.push_back(Address);
      if (ALU_EN) alu_seen.push_back(ALU_FUN);
      if (TX_D_VLD) tx_seen.push_back(TX_P_DATA);
      if (WrEn || RdEn || ALU_EN || TX_D_VLD)
        check("strobe_excl", 32'($countones({WrEn, RdEn, ALU_EN, TX_D_VLD}) > 1), 32'(0));
      if (ALU_EN) check("clk_en_with_alu_en", 32'(CLK_EN), 32'(1));
      if (!BUSY) check("clk_en_idle", 32'(CLK_EN), 32'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic vec_t mk(input int nb, input logic [39:0] bytes, input int rk,
                              input logic [15:0] resp, input int full, input int n_wr,
                              input logic [11:0] wr0, input logic [11:0] wr1, input int n_rd,
                              input logic [3:0] rd_addr, input int n_alu, input logic [3:0] fun,
                              input int n_tx, input logic [7:0] tx0, input logic [7:0] tx1);
    vec_t v;
    v.nb = nb; v.bytes = bytes; v.rk = rk; v.resp = resp; v.full = full;
    v.n_wr = n_wr; v.wr0 = wr0; v.wr1 = wr1; v.n_rd = n_rd; v.rd_addr = rd_addr;
    v.n_alu = n_alu; v.fun = fun; v.n_tx = n_tx; v.tx0 = tx0; v.tx1 = tx1;
    return v;
  endfunction

  // Frame-level reference: what each command must produce on the register/ALU/TX buses.
  function automatic vec_t model(input int kind, input logic [7:0] x0, input logic [7:0] x1,
                                 input logic [7:0] x2, input logic [15:0] resp, input int full,
                                 input logic [7:0] junk, input bit use_junk);
    vec_t v;
    logic [7:0] seq[$];
    v = mk(0, 40'h0, 0, resp, full, 0, 12'h0, 12'h0, 0, 4'h0, 0, 4'h0, 0, 8'h0, 8'h0);
    if (use_junk) seq.push_back(junk);
    case (kind)
      0: begin
        seq.push_back(8'hAA); seq.push_back(x0); seq.push_back(x1);
        v.n_wr = 1; v.wr0 = {x0[3:0], x1};
      end
      1: begin
        seq.push_back(8'hBB); seq.push_back(x0);
        v.n_rd = 1; v.rd_addr = x0[3:0]; v.rk = 1; v.n_tx = 1; v.tx0 = resp[7:0];
      end
      2: begin
        seq.push_back(8'hCC); seq.push_back(x0); seq.push_back(x1); seq.push_back(x2);
        v.n_wr = 2; v.wr0 = {4'h0, x0}; v.wr1 = {4'h1, x1};
        v.n_alu = 1; v.fun = x2[3:0]; v.rk = 2;
        v.n_tx = 2; v.tx0 = resp[7:0]; v.tx1 = resp[15:8];
      end
      default: begin
        seq.push_back(8'hDD); seq.push_back(x2);
        v.n_alu = 1; v.fun = x2[3:0]; v.rk = 2;
        v.n_tx = 2; v.tx0 = resp[7:0]; v.tx1 = resp[15:8];
      end
    endcase
    if (v.rk == 0) v.full = 0;
    v.nb = seq.size();
    for (int i = 0; i < seq.size(); i++) v.bytes[8*i +: 8] = seq[i];
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int gap, input bit stray);
    int n;
    wr_seen.delete(); rd_seen.delete(); alu_seen.delete(); tx_seen.delete();
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.bytes[8*i +: 8]);
      idle(gap);
    end
    if (v.rk != 0) begin
      idle(2);
      if (stray) send_byte(8'hAA);  // must be dropped while waiting for the response
      FIFO_FULL = (v.full != 0);
      if (v.rk == 1) begin
        RdData = v.resp[7:0]; RdData_Valid = 1'b1;
      end else begin
        ALU_OUT = v.resp; OUT_VALID = 1'b1;
      end
      @(posedge CLK);
      #1;
      RdData_Valid = 1'b0; OUT_VALID = 1'b0;
      RdData = ~v.resp[7:0]; ALU_OUT = ~v.resp;
      if (v.full != 0) begin
        idle(v.full);
        if (stray) send_byte(8'hBB);
        check("no_tx_while_full", 32'(tx_seen.size()), 32'(0));
        FIFO_FULL = 1'b0;
      end
    end
    n = 0;
    while (BUSY && n < 100) begin
      idle(1);
      n++;
    end
    check("busy_release", 32'(BUSY), 32'(0));
    idle(2);
    check("wr_count", 32'(wr_seen.size()), 32'(v.n_wr));
    for (int i = 0; i < v.n_wr && i < wr_seen.size(); i++)
      check("wr_addr_data", 32'(wr_seen[i]), 32'(i == 0 ? v.wr0 : v.wr1));
    check("rd_count", 32'(rd_seen.size()), 32'(v.n_rd));
    if (v.n_rd > 0 && rd_seen.size() > 0) check("rd_addr", 32'(rd_seen[0]), 32'(v.rd_addr));
    check("alu_count", 32'(alu_seen.size()), 32'(v.n_alu));
    if (v.n_alu > 0 && alu_seen.size() > 0) check("alu_fun", 32'(alu_seen[0]), 32'(v.fun));
    check("tx_count", 32'(tx_seen.size()), 32'(v.n_tx));
    for (int i = 0; i < v.n_tx && i < tx_seen.size(); i++)
      check("tx_byte", 32'(tx_seen[i]), 32'(i == 0 ? v.tx0 : v.tx1));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD,
                BUSY});
  endfunction

  initial begin
    vec_t tbl[8];
    vec_t v;
    logic [7:0] junk;
    int kind;

    tbl[0] = mk(3, 40'h77_05_AA, 0, 16'h0, 0, 1, 12'h577, 12'h0, 0, 4'h0, 0, 4'h0,
                0, 8'h0, 8'h0);
    tbl[1] = mk(2, 40'h02_BB, 1, 16'h005A, 0, 0, 12'h0, 12'h0, 1, 4'h2, 0, 4'h0,
                1, 8'h5A, 8'h0);
    tbl[2] = mk(4, 40'h01_03_05_CC, 2, 16'h000F, 0, 2, 12'h005, 12'h103, 0, 4'h0, 1, 4'h1,
                2, 8'h0F, 8'h00);
    tbl[3] = mk(2, 40'h01_DD, 2, 16'hBEEF, 10, 0, 12'h0, 12'h0, 0, 4'h0, 1, 4'h1,
                2, 8'hEF, 8'hBE);
    tbl[4] = mk(4, 40'h11_01_AA_3C, 0, 16'h0, 0, 1, 12'h111, 12'h0, 0, 4'h0, 0, 4'h0,
                0, 8'h0, 8'h0);
    tbl[5] = mk(3, 40'hC4_F3_AA, 0, 16'h0, 0, 1, 12'h3C4, 12'h0, 0, 4'h0, 0, 4'h0,
                0, 8'h0, 8'h0);
    tbl[6] = mk(2, 40'hFE_BB, 1, 16'h00A7, 3, 0, 12'h0, 12'h0, 1, 4'hE, 0, 4'h0,
                1, 8'hA7, 8'h0);
    tbl[7] = mk(2, 40'h9C_DD, 2, 16'h1234, 0, 0, 12'h0, 12'h0, 0, 4'h0, 1, 4'hC,
                2, 8'h34, 8'h12);

    // Reset state, with an opcode presented while reset is held.
    RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1;
    idle(3);
    check("reset_outputs", all_outs(), 32'(0));
    RX_D_VLD = 1'b0;
    RST = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 1, i[0]);

    // Write strobe lands in the cycle after the data byte.
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h77);
    check("wr_latency", 32'({WrEn, Address, WrData, BUSY}), 32'({1'b1, 4'h5, 8'h77, 1'b0}));
    idle(1);
    check("wr_single", 32'(WrEn), 32'(0));

    // Read strobe latency, then TX one cycle after the capture edge.
    send_byte(8'hBB);
    send_byte(8'h02);
    check("rd_latency", 32'({RdEn, Address}), 32'({1'b1, 4'h2}));
    idle(1);
    check("rd_single", 32'(RdEn), 32'(0));
    RdData = 8'h5A; RdData_Valid = 1'b1;
    idle(1);
    RdData_Valid = 1'b0; RdData = 8'h00;
    check("tx_not_yet", 32'(TX_D_VLD), 32'(0));
    idle(1);
    check("tx_latency", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, 8'h5A}));
    idle(1);
    check("tx_single", 32'({TX_D_VLD, BUSY}), 32'(0));

    // ALU enable latency and clock-gate window.
    send_byte(8'hDD);
    check("clk_en_fun", 32'({CLK_EN, BUSY}), 32'(3));
    send_byte(8'h03);
    check("alu_latency", 32'({ALU_EN, ALU_FUN, CLK_EN}), 32'({1'b1, 4'h3, 1'b1}));
    ALU_OUT = 16'h0102; OUT_VALID = 1'b1;
    idle(1);
    OUT_VALID = 1'b0;
    check("clk_en_tx", 32'(CLK_EN), 32'(0));
    idle(4);
    check("alu_done", 32'(BUSY), 32'(0));

    // Asynchronous reset in the middle of an ALU frame.
    send_byte(8'hCC);
    send_byte(8'h05);
    #2;
    RST = 1'b1;
    #1;
    check("reset_mid_cmd", all_outs(), 32'(0));
    idle(2);
    RST = 1'b0;
    idle(1);
    run_vec(mk(2, 40'h00_BB, 1, 16'h00C3, 0, 0, 12'h0, 12'h0, 1, 4'h0, 0, 4'h0,
               1, 8'hC3, 8'h0), 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      junk = 8'($urandom);
      while (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD)
        junk = 8'($urandom);
      v = model(kind, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0,
                junk, $urandom_range(0, 3) == 0);
      run_vec(v, int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
